// File: rtl/dotseq_pkg.sv
// Shared types and constants for the dot-product sequencer and its watchdog.
package dotseq_pkg;

  localparam int FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_RESULT
  } state_t;

endpackage

// File: rtl/dotseq_watchdog.sv
// WAIT-state timeout counter; only instantiated when DOTSEQ_TIMEOUT_EN is defined.
module dotseq_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  // Fires on the LIMIT-th enabled cycle after a clear.
  assign expired = en && (count == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dot_product_sequencer.sv
// Streams K operand pairs through one FP16 MAC unit and returns the accumulated result.
// Optional WAIT-state watchdog is enabled with `define DOTSEQ_TIMEOUT_EN.
module dot_product_sequencer
  import dotseq_pkg::*;
#(
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [FP16_W-1:0] op_a,
  input  logic [FP16_W-1:0] op_b,
  output logic              pu_start,
  output logic [FP16_W-1:0] pu_a,
  output logic [FP16_W-1:0] pu_b,
  output logic              pu_clr,
  input  logic              pu_ready,
  input  logic [FP16_W-1:0] pu_p,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [FP16_W-1:0] res_data,
  output logic              res_err
);

  localparam logic [LEN_W-1:0] REM_ONE = LEN_W'(1);

  if (LEN_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("dot_product_sequencer: LEN_W and TIMEOUT_CYC must be positive");
  end

  state_t           state;
  logic [LEN_W-1:0] rem;

`ifdef DOTSEQ_TIMEOUT_EN
  logic timeout;

  // Entering WAIT always passes through ISSUE, so clearing there restarts the count.
  dotseq_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == S_ISSUE),
    .en      (state == S_WAIT),
    .expired (timeout)
  );
`else
  assign res_err = 1'b0;
`endif

  // All handshake outputs are registered: each is set on the transition into the state that owns it.
  // NOTE: state and outputs use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rem       <= '0;
      cmd_ready <= 1'b1;
      op_ready  <= 1'b0;
      pu_start  <= 1'b0;
      pu_clr    <= 1'b0;
      res_valid <= 1'b0;
      pu_a      <= FP16_ZERO;
      pu_b      <= FP16_ZERO;
      res_data  <= FP16_ZERO;
`ifdef DOTSEQ_TIMEOUT_EN
      res_err   <= 1'b0;
`endif
    end else begin
      pu_start <= 1'b0;
      pu_clr   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            rem       <= cmd_len;
            cmd_ready <= 1'b0;
            pu_clr    <= 1'b1;
            state     <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          if (rem == '0) begin
            res_data  <= FP16_ZERO;
            res_valid <= 1'b1;
            state     <= S_RESULT;
          end else begin
            op_ready <= 1'b1;
            state    <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (op_valid) begin
            pu_a     <= op_a;
            pu_b     <= op_b;
            op_ready <= 1'b0;
            pu_start <= 1'b1;
            state    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (pu_ready) begin
            if (rem != '0) begin
              rem <= rem - REM_ONE;
            end
            if (rem == REM_ONE) begin
              res_data  <= pu_p;
              res_valid <= 1'b1;
              state     <= S_RESULT;
            end else begin
              op_ready <= 1'b1;
              state    <= S_FETCH;
            end
          end
`ifdef DOTSEQ_TIMEOUT_EN
          else if (timeout) begin
            pu_clr    <= 1'b1;
            res_err   <= 1'b1;
            res_data  <= FP16_ZERO;
            res_valid <= 1'b1;
            state     <= S_RESULT;
          end
`endif
        end

        S_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
`ifdef DOTSEQ_TIMEOUT_EN
            res_err   <= 1'b0;
`endif
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dot_product_sequencer.md
# dot_product_sequencer

Controller that runs one FP16 multiply-accumulate processing unit over a K-element dot product. It accepts a job command, clears the unit's accumulator, and streams K operand pairs through the unit using its start/ready handshake. It then returns the final accumulated value on a result handshake. It sits between the operand buffers and a single processing unit in the TPU array tile.

## Interface
- `LEN_W`, 8: width of job length; max K = 2^LEN_W − 1
- `TIMEOUT_CYC`, 64: watchdog limit in cycles per element (used only with the macro)
- `clk`  in  1  clock, single domain
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  job request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_len`  in  LEN_W  element count K, sampled on accept
- `op_valid`  in  1  operand pair available
- `op_ready`  out  1  high only in FETCH
- `op_a`, `op_b`  in  16  FP16 operands
- `pu_start`  out  1  one-cycle start pulse to the processing unit
- `pu_a`, `pu_b`  out  16  registered operands, held stable from pu_start until pu_ready
- `pu_clr`  out  1  one-cycle accumulator clear; ORed into the unit's reset at tile level
- `pu_ready`  in  1  unit completion pulse
- `pu_p`  in  16  unit accumulator output
- `res_valid`  out  1  result available
- `res_ready`  in  1  result accepted
- `res_data`  out  16  FP16 dot-product result
- `res_err`  out  1  result aborted by watchdog (0 when the macro is off)

## Operation
- States: IDLE, CLEAR, FETCH, ISSUE, WAIT, RESULT.
- **IDLE:** cmd_ready=1. On cmd_valid, latch `rem` = cmd_len and go to CLEAR.
- **CLEAR:** pu_clr=1 for exactly one cycle.
  - If rem==0, res_data=16'h0000 and go to RESULT.
  - Otherwise go to FETCH.
- **FETCH:** op_ready=1. On op_valid, latch op_a/op_b into pu_a/pu_b and go to ISSUE.
- **ISSUE:** pu_start=1 for one cycle, then go to WAIT.
- **WAIT:** hold pu_a/pu_b. On pu_ready, rem ← rem−1.
  - If rem was 1, latch res_data ← pu_p and go to RESULT.
  - Otherwise go to FETCH.
- **RESULT:** res_valid=1 with res_data and res_err stable until res_ready. On accept, go to IDLE.
- rem is unsigned, LEN_W bits, and never wraps: it is decremented only when nonzero.
- No FP arithmetic is done in this block; res_data is pu_p verbatim.
- A pu_ready seen outside WAIT is ignored.
- Reset values:
  - state=IDLE, rem=0
  - cmd_ready=1 in the first cycle after reset
  - op_ready, pu_start, pu_clr, res_valid, res_err = 0
  - pu_a, pu_b, res_data = 16'h0000
- Reset mid-job abandons the job with no result; the unit is reset by the system reset.

## Timing
- Command accepted at cycle T: pu_clr is high at T+1 and op_ready at T+2.
- Operand accepted at cycle F: pu_start is high at F+1.
- pu_start is never asserted in the same cycle as pu_ready. The next pu_start comes at the earliest 2 cycles after pu_ready (FETCH then ISSUE).
- Per-element cost is the unit latency (about 12 cycles) plus 2 cycles. Total job latency is 2 + K·(L+2) + 1 cycles to res_valid.
- cmd_valid during a job is ignored, since cmd_ready=0; the next command is accepted in the cycle after the result is accepted.
- op_valid and res_ready may toggle arbitrarily; stalls only extend FETCH or RESULT.

## Configuration
- `DOTSEQ_TIMEOUT_EN` defined:
  - A WAIT cycle counter is cleared on entry to WAIT.
  - If it reaches TIMEOUT_CYC without pu_ready: pulse pu_clr, set res_err=1 and res_data=16'h0000, and go to RESULT.
  - res_err clears on result accept.
- Undefined: no counter is built, WAIT waits indefinitely, and res_err is tied 0.

## Structure
- Package `dotseq_pkg` holds:
  - the state enum
  - `FP16_W` = 16
  - `FP16_ZERO` = 16'h0000
- Sub-module `dotseq_watchdog` holds the timeout counter (clear, enable, expire). It is instantiated only under `DOTSEQ_TIMEOUT_EN`.

## Test plan
- cmd_len=2, pairs (0x3C00, 0x4200) and (0x4000, 0x4400) -> res_data=0x4980 (11.0), res_err=0, exactly two pu_start and one pu_clr pulse.
- cmd_len=1, pair (0x4000, 0x4200), then a second job with the same pair -> both results are 0x4600, confirming the clear between jobs.
- cmd_len=0 -> pu_clr pulse, no pu_start, res_data=0x0000 with res_valid 2 cycles after accept.
- Stall op_valid for 5 cycles in FETCH and hold res_ready low for 4 cycles -> pu_a/pu_b/res_data stay stable, and cmd_ready stays low until the result is accepted.
- Assert reset during WAIT of a 3-element job -> the next cycle shows IDLE values, and a fresh cmd_len=1 job completes correctly.
- With `DOTSEQ_TIMEOUT_EN` and a unit model that never returns pu_ready -> after 64 WAIT cycles, res_valid=1, res_err=1, res_data=0x0000.
